// File: rtl/hsid_x_ctrl_responder.sv
// rtl/hsid_x_ctrl_responder.sv - HSID-X control register responder and start/run/done/clear/cancel FSM
// Optional interrupt output enabled by defining HSID_X_CTRL_IRQ_EN.

package hsid_x_ctrl_pkg;
  localparam int REG_DW = 32;

  typedef struct packed {
    logic [REG_DW-1:0] addr;
    logic              write;
    logic [REG_DW-1:0] wdata;
    logic [3:0]        wstrb;
    logic              valid;
  } reg_req_t;

  typedef struct packed {
    logic [REG_DW-1:0] rdata;
    logic              error;
    logic              ready;
  } reg_rsp_t;
endpackage

module hsid_x_ctrl_responder
  import hsid_x_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH = REG_DW,
  parameter int BLOCK_AW   = 6,
  parameter int LIB_W      = 8,
  parameter int BANDS_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  reg_req_t           reg_req_i,
  output reg_rsp_t           reg_rsp_o,
  output logic               start_o,
  output logic               clear_o,
  output logic               cancel_o,
  output logic [LIB_W-1:0]   library_size_o,
  output logic [BANDS_W-1:0] pixel_bands_o,
  output logic [31:0]        captured_pixel_addr_o,
  output logic [31:0]        library_pixel_addr_o,
  input  logic               idle_i,
  input  logic               ready_i,
  input  logic               done_i,
  input  logic               error_i,
  input  logic [LIB_W-1:0]   mse_min_ref_i,
  input  logic [LIB_W-1:0]   mse_max_ref_i,
  input  logic [31:0]        mse_min_value_i,
  input  logic [31:0]        mse_max_value_i
`ifdef HSID_X_CTRL_IRQ_EN
  ,
  output logic               irq_o
`endif
);

  localparam logic [BLOCK_AW-1:0] A_STATUS  = BLOCK_AW'('h00);
  localparam logic [BLOCK_AW-1:0] A_LIBSIZE = BLOCK_AW'('h04);
  localparam logic [BLOCK_AW-1:0] A_BANDS   = BLOCK_AW'('h08);
  localparam logic [BLOCK_AW-1:0] A_CAPADDR = BLOCK_AW'('h0C);
  localparam logic [BLOCK_AW-1:0] A_LIBADDR = BLOCK_AW'('h10);
  localparam logic [BLOCK_AW-1:0] A_MINREF  = BLOCK_AW'('h14);
  localparam logic [BLOCK_AW-1:0] A_MAXREF  = BLOCK_AW'('h18);
  localparam logic [BLOCK_AW-1:0] A_MINVAL  = BLOCK_AW'('h1C);
  localparam logic [BLOCK_AW-1:0] A_MAXVAL  = BLOCK_AW'('h20);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_FAULT,
    S_CANCELLED
  } state_t;

  state_t               r_state;
  logic                 r_done_st;
  logic                 r_err_st;
  logic                 r_can_st;
  logic [LIB_W-1:0]     r_lib_size;
  logic [BANDS_W-1:0]   r_bands;
  logic [31:0]          r_cap_addr;
  logic [31:0]          r_lib_addr;
  reg_rsp_t             r_rsp;
  logic                 r_start;
  logic                 r_clear;
  logic                 r_cancel;

  logic [BLOCK_AW-1:0]  w_off;
  logic                 w_accept;
  logic                 w_mapped;
  logic                 w_ro;
  logic                 w_cfg;
  logic                 w_err;
  logic                 w_wr_ok;
  logic [7:0]           w_cmd;
  logic [WORD_WIDTH-1:0] w_rdata;
  state_t               w_state_nxt;
  logic                 w_done_nxt;
  logic                 w_err_nxt;
  logic                 w_can_nxt;
  logic                 w_start_p;
  logic                 w_clear_p;
  logic                 w_cancel_p;
  logic                 w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? wd[8*b +: 8] : old[8*b +: 8];
    end
    return res;
  endfunction

  assign w_off    = reg_req_i.addr[BLOCK_AW-1:0];
  assign w_unused = ^reg_req_i.addr[REG_DW-1:BLOCK_AW];
  assign w_accept = reg_req_i.valid & ~r_rsp.ready;
  assign w_cmd    = reg_req_i.wdata[7:0] & {8{reg_req_i.wstrb[0]}};
  assign w_ro     = (w_off == A_MINREF) | (w_off == A_MAXREF) |
                    (w_off == A_MINVAL) | (w_off == A_MAXVAL);
  assign w_cfg    = (w_off == A_LIBSIZE) | (w_off == A_BANDS) |
                    (w_off == A_CAPADDR) | (w_off == A_LIBADDR);

  always_comb begin
    w_rdata  = '0;
    w_mapped = 1'b1;
    case (w_off)
      A_STATUS:  w_rdata = WORD_WIDTH'({r_can_st, r_err_st, 1'b0, r_done_st, ready_i, idle_i, 1'b0});
      A_LIBSIZE: w_rdata = WORD_WIDTH'(r_lib_size);
      A_BANDS:   w_rdata = WORD_WIDTH'(r_bands);
      A_CAPADDR: w_rdata = WORD_WIDTH'(r_cap_addr);
      A_LIBADDR: w_rdata = WORD_WIDTH'(r_lib_addr);
      A_MINREF:  w_rdata = WORD_WIDTH'(mse_min_ref_i);
      A_MAXREF:  w_rdata = WORD_WIDTH'(mse_max_ref_i);
      A_MINVAL:  w_rdata = WORD_WIDTH'(mse_min_value_i);
      A_MAXVAL:  w_rdata = WORD_WIDTH'(mse_max_value_i);
      default:   w_mapped = 1'b0;
    endcase
  end

  // START is only refused when it would actually be acted on (no CLEAR, FSM idle).
  assign w_err = (reg_req_i.addr[1:0] != 2'b00) | ~w_mapped |
                 (reg_req_i.write & w_ro) |
                 (reg_req_i.write & w_cfg & (r_state == S_BUSY)) |
                 (reg_req_i.write & (w_off == A_STATUS) & w_cmd[0] & ~w_cmd[4] &
                  (r_state == S_IDLE) & ~idle_i);
  assign w_wr_ok = w_accept & ~w_err & reg_req_i.write;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = r_done_st;
    w_err_nxt   = r_err_st;
    w_can_nxt   = r_can_st;
    w_start_p   = 1'b0;
    w_clear_p   = 1'b0;
    w_cancel_p  = 1'b0;
    if (r_state == S_BUSY) begin
      if (error_i) begin
        w_state_nxt = S_FAULT;
        w_err_nxt   = 1'b1;
        w_done_nxt  = r_done_st | done_i;
      end else if (done_i) begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end
    end
    if (w_wr_ok && (w_off == A_STATUS)) begin
      if (w_cmd[4]) begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_can_nxt   = 1'b0;
        w_clear_p   = 1'b1;
      end else if (w_cmd[0] && (r_state == S_IDLE)) begin
        w_state_nxt = S_BUSY;
        w_start_p   = 1'b1;
      end else if (w_cmd[6] && (r_state == S_BUSY)) begin
        w_state_nxt = S_CANCELLED;
        w_can_nxt   = 1'b1;
        w_cancel_p  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_done_st  <= 1'b0;
      r_err_st   <= 1'b0;
      r_can_st   <= 1'b0;
      r_lib_size <= '0;
      r_bands    <= '0;
      r_cap_addr <= '0;
      r_lib_addr <= '0;
      r_rsp      <= '0;
      r_start    <= 1'b0;
      r_clear    <= 1'b0;
      r_cancel   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done_st <= w_done_nxt;
      r_err_st  <= w_err_nxt;
      r_can_st  <= w_can_nxt;
      r_start   <= w_start_p;
      r_clear   <= w_clear_p;
      r_cancel  <= w_cancel_p;
      if (w_wr_ok && (w_off == A_LIBSIZE))
        r_lib_size <= LIB_W'(f_merge(32'(r_lib_size), reg_req_i.wdata, reg_req_i.wstrb));
      if (w_wr_ok && (w_off == A_BANDS))
        r_bands <= BANDS_W'(f_merge(32'(r_bands), reg_req_i.wdata, reg_req_i.wstrb));
      if (w_wr_ok && (w_off == A_CAPADDR))
        r_cap_addr <= f_merge(r_cap_addr, reg_req_i.wdata, reg_req_i.wstrb);
      if (w_wr_ok && (w_off == A_LIBADDR))
        r_lib_addr <= f_merge(r_lib_addr, reg_req_i.wdata, reg_req_i.wstrb);
      r_rsp.ready <= w_accept;
      r_rsp.error <= w_accept & w_err;
      r_rsp.rdata <= (w_accept & ~w_err & ~reg_req_i.write) ? w_rdata : '0;
    end
  end

`ifdef HSID_X_CTRL_IRQ_EN
  logic r_irq;

  // Driven from next-state stickies so a CLEAR drops irq together with ready.
  always_ff @(posedge clk) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= w_done_nxt | w_err_nxt;
  end

  assign irq_o = r_irq;
`endif

  assign reg_rsp_o             = r_rsp;
  assign start_o               = r_start;
  assign clear_o               = r_clear;
  assign cancel_o              = r_cancel;
  assign library_size_o        = r_lib_size;
  assign pixel_bands_o         = r_bands;
  assign captured_pixel_addr_o = r_cap_addr;
  assign library_pixel_addr_o  = r_lib_addr;

endmodule

// File: doc/hsid_x_ctrl_responder.md
# hsid_x_ctrl_responder

Register-bus responder for the HSID-X accelerator: accepts `reg_req_t` transactions from the host initiator, decodes the nine control registers, returns `reg_rsp_t`, and sequences the core through a start/run/done/clear/cancel control state machine. It sits between the host register bus and the HSID core, converting register writes into configuration outputs and single-cycle command pulses, and converting core results into readable registers.

## Interface
- `WORD_WIDTH`, 32, bus data width
- `BLOCK_AW`, 6, decoded address bits; `addr[WORD_WIDTH-1:BLOCK_AW]` ignored
- `LIB_W`, 8, library size and MSE reference index width
- `BANDS_W`, 8, pixel band count width
- `clk` in 1, single clock
- `rst_n` in 1, reset, synchronous, active-low
- `reg_req_i` in `reg_req_t`, carries addr, write, wdata, wstrb[3:0], valid
- `reg_rsp_o` out `reg_rsp_t`, carries rdata, error, ready
- `start_o`, `clear_o`, `cancel_o` out 1, one-cycle command pulses to the core
- `library_size_o` out LIB_W; `pixel_bands_o` out BANDS_W
- `captured_pixel_addr_o`, `library_pixel_addr_o` out 32
- `idle_i`, `ready_i`, `done_i`, `error_i` in 1, core status
- `mse_min_ref_i`, `mse_max_ref_i` in LIB_W; `mse_min_value_i`, `mse_max_value_i` in 32
- `irq_o` out 1, present only with `HSID_X_CTRL_IRQ_EN`

## Operation
- Register map, byte offsets: 0x00 STATUS, 0x04 LIBRARY_SIZE, 0x08 PIXEL_BANDS, 0x0C CAPTURED_PIXEL_ADDR, 0x10 LIBRARY_PIXEL_ADDR, 0x14 MSE_MIN_REF, 0x18 MSE_MAX_REF, 0x1C MSE_MIN_VALUE, 0x20 MSE_MAX_VALUE.
- STATUS bits: [0] START, [1] IDLE, [2] READY, [3] DONE, [4] CLEAR, [5] ERROR, [6] CANCELLED. Reads return 0 for START and CLEAR. IDLE and READY are live copies of `idle_i` and `ready_i`. DONE, ERROR and CANCELLED are sticky.
- Writable registers are STATUS (command bits 0, 4, 6 only) and offsets 0x04–0x10. Offsets 0x14–0x20 are read-only and return the core inputs, zero-extended.
- Byte-lane writes follow `wstrb`. Bits above the register width are discarded.
- The response error flag is set, with no state change, for any of the following: unmapped offset, `addr[1:0]≠0`, a write to a read-only offset, or a write to 0x04–0x10 while the FSM is in BUSY. Errored reads return `rdata=0`.
- FSM states: IDLE, BUSY, DONE, FAULT, CANCELLED.
  - IDLE: writing START=1 with `idle_i=1` pulses `start_o` and moves to BUSY. Writing START while `idle_i=0` returns error.
  - BUSY: `done_i` moves to DONE and sets sticky DONE. `error_i` moves to FAULT and sets sticky ERROR. Writing CANCELLED=1 pulses `cancel_o`, sets sticky CANCELLED and moves to CANCELLED.
  - Any state: writing CLEAR=1 pulses `clear_o`, clears all sticky bits and moves to IDLE.
  - Within a single STATUS write, CLEAR takes priority over START, which takes priority over CANCELLED.
  - If `error_i` and `done_i` are high in the same cycle, the FSM moves to FAULT and sets both sticky bits.
  - START written outside IDLE and CANCELLED written outside BUSY are ignored. These writes do not set the error flag.

## Timing
- A request is accepted in any cycle where `valid=1` and no response is pending. The response is registered: `ready=1` exactly one cycle later, for exactly one cycle, with rdata and error valid in that cycle.
- The responder handles one outstanding transaction. A `valid` asserted in the `ready` cycle is accepted as a new request in the following cycle.
- Command pulses and register updates appear in the cycle after acceptance, coincident with `ready`.
- Sticky bits set by `done_i` or `error_i` in cycle N are visible to a read accepted in cycle N+1.
- Reset values: all outputs 0, all registers 0, FSM in IDLE, `reg_rsp_o` all 0. Reset asserted mid-transaction drops the pending response.

## Configuration
- `HSID_X_CTRL_IRQ_EN` defined: adds `irq_o`, registered, high while sticky DONE or ERROR is set, and low the cycle after a CLEAR is accepted.
- Macro undefined: the `irq_o` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then read STATUS with `idle_i=1`, `ready_i=1` → rdata=0x06, error=0, `ready` one cycle after `valid`.
- Write LIBRARY_SIZE=0x25 with wstrb=4'b0001, then write 0x3F00 with wstrb=4'b0010 → read returns 0x25 and `library_size_o`=0x25.
- Write START=1 in IDLE → `start_o` pulses once. Write PIXEL_BANDS during BUSY → error=1 and the value is unchanged. Raise `done_i` → STATUS read returns DONE set, 0x0A with `idle_i=1`.
- Drive `mse_min_value_i`=0x1234 and `mse_max_ref_i`=7 → reads return 0x1234 and 0x7. Write to 0x1C → error=1. Read offset 0x24 → error=1, rdata=0.
- From BUSY, write STATUS=0x40 → `cancel_o` pulses and CANCELLED is set. Write STATUS=0x11 → only `clear_o` pulses, the FSM returns to IDLE, and STATUS reads 0x02.
- Raise `error_i` and `done_i` together in BUSY → STATUS reads ERROR and DONE set. With the macro defined, `irq_o`=1 until CLEAR, then 0 on the next cycle.
